// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the data memory responder: FSM state encoding,
// word-index sizing and the request error check.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int idx_width(input int unsigned depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

  // Misaligned (not word aligned) or beyond the last storage word.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth_words);
    logic [63:0] limit;
    limit = 64'(depth_words) * 64'd4;
    return (addr[1:0] != 2'b00) || (addr >= limit);
  endfunction

endpackage

// File: rtl/data_mem_responder_mem_array.sv
// Word-addressed storage with byte-lane write enables and a registered read port.
// Contents are deliberately not reset.
module mem_array
  import mem_resp_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  localparam int IW         = idx_width(DEPTH_WORDS)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [IW-1:0]      idx,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH/8; i++) begin
      if (we && wstrb[i]) r_mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    // Read-before-write: a store's own commit edge returns the old word.
    rdata <= r_mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: single-transaction valid/ready front end, programmable
// wait states, error screening and a registered response in front of mem_array.
//
// state | meaning
// IDLE  | ready for a request; a one-cycle pending slot follows each acceptance
// WAIT  | wait states; counter runs WAIT_CYCLES-1 down to 0
// RESP  | response presented; held until rsp_ready
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic               rsp_err
);

  localparam int IW = idx_width(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t r_state, w_state_nxt;
  logic   r_pend;
  logic [CW-1:0] r_cnt;

  logic               r_write;
  logic               r_err;
  logic [IW-1:0]      r_idx;
  logic [WIDTH-1:0]   r_wdata;
  logic [WIDTH/8-1:0] r_wstrb;

  logic               w_accept;
  logic               w_enter_resp;
  logic               w_we;
  logic [WIDTH-1:0]   w_mem_rdata;

  assign w_accept     = (r_state == IDLE) && !r_pend && req_valid;
  assign w_enter_resp = (r_state != RESP) && (w_state_nxt == RESP);
  assign w_we         = w_enter_resp && r_write && !r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (r_pend) w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) r_pend <= 1'b1;
      else if (r_state == IDLE) r_pend <= 1'b0;

      if (r_state == IDLE && r_pend) r_cnt <= CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
      else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Request latch; only meaningful while a transaction is in flight.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write <= req_write;
      r_err   <= addr_err(64'(req_addr), DEPTH_WORDS);
      r_idx   <= req_addr[IW+1:2];
      r_wdata <= req_wdata;
      r_wstrb <= req_wstrb;
    end
  end

  mem_array #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .wstrb (r_wstrb),
    .idx   (r_idx),
    .wdata (r_wdata),
    .rdata (w_mem_rdata)
  );

  assign req_ready = (r_state == IDLE) && !r_pend;
  assign rsp_valid = (r_state == RESP);
  assign rsp_err   = (r_state == RESP) && r_err;
  // The read register is frozen while in RESP: index and contents cannot change.
  assign rsp_rdata = ((r_state == RESP) && !r_write && !r_err) ? w_mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance for the main tests and a
// WAIT_CYCLES=0 instance for the backpressure/zero-wait case.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_req_valid = 0, a_req_write = 0, a_rsp_ready = 1;
  logic [31:0] a_req_addr = '0, a_req_wdata = '0;
  logic [3:0]  a_req_wstrb = '0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid = 0, b_req_write = 0, b_rsp_ready = 1;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic [3:0]  b_req_wstrb = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_responder #(.WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // Full transaction on dut_a with rsp_ready high; reports latency from the
  // acceptance edge to rsp_valid, the response fields, and any cycle where
  // req_ready was high while the transaction was in flight.
  task automatic xact_a(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output int lat, output logic [31:0] rd,
                        output logic er, output int rdy_viol);
    int guard = 0;
    while (!a_req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    a_req_valid = 1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd; a_req_wstrb = st;
    @(posedge clk); #1;
    a_req_valid = 0;
    lat = 0; rdy_viol = 0;
    while (!a_rsp_valid && lat < 50) begin
      if (a_req_ready) rdy_viol++;
      @(posedge clk); #1; lat++;
    end
    rd = a_rsp_rdata; er = a_rsp_err;
    if (a_req_ready) rdy_viol++;
    @(posedge clk); #1;
  endtask

  task automatic xact_b(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, output int lat, output logic [31:0] rd,
                        output logic er);
    int guard = 0;
    while (!b_req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    b_req_valid = 1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd; b_req_wstrb = st;
    @(posedge clk); #1;
    b_req_valid = 0;
    lat = 0;
    while (!b_rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    rd = b_rsp_rdata; er = b_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
    n_checks++; if (a_rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
    n_checks++; if (a_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
    n_checks++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b ready=%b valid=%b exp=1/0", b_req_ready, b_rsp_valid); end
    @(negedge clk); rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset ready=%b valid=%b exp=1/0", a_req_ready, a_rsp_valid); end
  endtask

  task automatic test_store_load();
    int lat, viol; logic [31:0] rd; logic er;
    xact_a(1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er, viol);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL store_latency got=%0d exp=3", lat); end
    n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL store_rsp err=%b rdata=%h exp=0/0", er, rd); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL store_req_ready_busy got=%0d cycles exp=0", viol); end
    n_checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL after_handshake ready=%b valid=%b exp=1/0", a_req_ready, a_rsp_valid); end
    xact_a(0, 32'h10, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency got=%0d exp=3", lat); end
    n_checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_fail++; $display("FAIL load_data got=%h err=%b exp=deadbeef/0", rd, er); end
  endtask

  task automatic test_partial_strobe();
    int lat, viol; logic [31:0] rd; logic er;
    xact_a(1, 32'h10, 32'h000000AA, 4'b0001, lat, rd, er, viol);
    xact_a(0, 32'h10, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL partial_strobe got=%h exp=deadbeaa", rd); end
    xact_a(1, 32'h10, 32'h55555555, 4'b0000, lat, rd, er, viol);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL zero_strobe_err got=%b exp=0", er); end
    xact_a(0, 32'h10, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL zero_strobe_noop got=%h exp=deadbeaa", rd); end
    xact_a(1, 32'h14, 32'hA1B2C3D4, 4'b1010, lat, rd, er, viol);
    xact_a(1, 32'h14, 32'h00000000, 4'b0101, lat, rd, er, viol);
    xact_a(0, 32'h14, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (rd !== 32'hA100C300) begin n_fail++; $display("FAIL lane_mix got=%h exp=a100c300", rd); end
  endtask

  task automatic test_errors();
    int lat, viol; logic [31:0] rd; logic er;
    xact_a(1, 32'h0, 32'h11223344, 4'hF, lat, rd, er, viol);
    xact_a(0, 32'h13, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_load err=%b rdata=%h exp=1/0", er, rd); end
    xact_a(1, 32'h400, 32'hFFFFFFFF, 4'hF, lat, rd, er, viol);
    n_checks++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL oor_store err=%b rdata=%h exp=1/0", er, rd); end
    xact_a(1, 32'h12, 32'hFFFFFFFF, 4'hF, lat, rd, er, viol);
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL misaligned_store err=%b exp=1", er); end
    xact_a(0, 32'h0, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (rd !== 32'h11223344 || er !== 1'b0) begin n_fail++; $display("FAIL word0_unchanged got=%h err=%b exp=11223344/0", rd, er); end
    xact_a(0, 32'h10, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (rd !== 32'hDEADBEAA) begin n_fail++; $display("FAIL word4_unchanged got=%h exp=deadbeaa", rd); end
    xact_a(0, 32'h3FC, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_err got=%b exp=0", er); end
  endtask

  task automatic test_backpressure_zero_wait();
    int lat, stable_bad; logic [31:0] rd; logic er;
    xact_b(1, 32'h40, 32'hCAFEF00D, 4'hF, lat, rd, er);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zw_store_latency got=%0d exp=1", lat); end
    b_rsp_ready = 0;
    b_req_valid = 1; b_req_write = 0; b_req_addr = 32'h40;
    @(posedge clk); #1;
    b_req_valid = 0;
    n_checks++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL zw_early_valid got=%b exp=0", b_rsp_valid); end
    @(posedge clk); #1;
    n_checks++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid_next_cycle got=%b exp=1", b_rsp_valid); end
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'hCAFEF00D || b_req_ready !== 1'b0) stable_bad++;
      @(posedge clk); #1;
    end
    n_checks++; if (stable_bad !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d bad cycles exp=0 (rdata=%h)", stable_bad, b_rsp_rdata); end
    b_rsp_ready = 1;
    @(posedge clk); #1;
    n_checks++; if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release valid=%b ready=%b exp=0/1", b_rsp_valid, b_req_ready); end
  endtask

  task automatic test_reset_mid_store();
    int lat, viol; logic [31:0] rd; logic er;
    xact_a(1, 32'h20, 32'h0BADCAFE, 4'hF, lat, rd, er, viol);
    a_req_valid = 1; a_req_write = 1; a_req_addr = 32'h20; a_req_wdata = 32'h12345678; a_req_wstrb = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    #1;
    n_checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL mid_reset_outputs ready=%b valid=%b rdata=%h err=%b exp=1/0/0/0", a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL dropped_response got=%b exp=0", a_rsp_valid); end
    xact_a(0, 32'h20, 32'h0, 4'h0, lat, rd, er, viol);
    n_checks++; if (rd !== 32'h0BADCAFE) begin n_fail++; $display("FAIL store_not_committed got=%h exp=0badcafe", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_strobe();
    test_errors();
    test_backpressure_zero_wait();
    test_reset_mid_store();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
